// File: rtl/mem_pkg.sv
// Shared encodings and the request legality check for the memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10,
      MEM_RSVD = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } mem_state_e;

   localparam int unsigned CNT_W = 4;

   // Reserved size, misalignment and out-of-range word index all flag an error.
   function automatic logic mem_req_err(input mem_size_e   size,
                                        input logic [31:0] addr,
                                        input int unsigned depth_words);
      logic err;
      err = 1'b0;
      case (size)
         MEM_HALF: err = addr[0];
         MEM_WORD: err = |addr[1:0];
         MEM_RSVD: err = 1'b1;
         default:  err = 1'b0;
      endcase
      if ({2'b00, addr[31:2]} >= depth_words) begin
         err = 1'b1;
      end
      return err;
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
module mem_word_array #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned IDX_W       = 8
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [3:0]       be_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [0:DEPTH_WORDS-1];
   logic [31:0] rdata_q;

   // Contents are deliberately not reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (be_i[lane]) begin
               mem_q[idx_i][lane*8 +: 8] <= wdata_i[lane*8 +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Handshaked memory slave with fixed wait states, byte-lane steering and error flagging.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q;
   mem_size_e        size_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;

   logic             act_write;
   mem_size_e        act_size;
   logic [31:0]      act_addr;
   logic [31:0]      act_wdata;
   logic             act_err;
   logic             lat_err;
   logic             commit;
   logic [3:0]       wr_be;
   logic [31:0]      wr_data;
   logic [31:0]      ram_rdata;
   logic [31:0]      ld_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         size_q  <= MEM_BYTE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && req_valid_i) begin
            write_q <= req_write_i;
            size_q  <= mem_size_e'(req_size_i);
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
      end
   end

   // With zero wait states the commit edge is the accept edge, so the live inputs drive the array.
   always_comb begin
      if (state_q == IDLE) begin
         act_write = req_write_i;
         act_size  = mem_size_e'(req_size_i);
         act_addr  = req_addr_i;
         act_wdata = req_wdata_i;
      end else begin
         act_write = write_q;
         act_size  = size_q;
         act_addr  = addr_q;
         act_wdata = wdata_q;
      end
   end

   assign act_err = mem_req_err(act_size, act_addr, DEPTH_WORDS);
   assign lat_err = mem_req_err(size_q, addr_q, DEPTH_WORDS);
   assign commit  = (state_d == RESP) && (state_q != RESP);

   always_comb begin
      wr_be   = 4'hF;
      wr_data = act_wdata;
      case (act_size)
         MEM_BYTE: begin
            wr_be   = 4'b0001 << act_addr[1:0];
            wr_data = {4{act_wdata[7:0]}};
         end
         MEM_HALF: begin
            wr_be   = act_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{act_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   mem_word_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk    (clk),
      .we_i   (commit && act_write && !act_err),
      .re_i   (commit && !act_write && !act_err),
      .be_i   (wr_be),
      .idx_i  (act_addr[IDX_W+1:2]),
      .wdata_i(wr_data),
      .rdata_o(ram_rdata)
   );

   always_comb begin
      ld_data = ram_rdata;
      case (size_q)
         MEM_BYTE: ld_data = {24'b0, ram_rdata[{addr_q[1:0], 3'b000} +: 8]};
         MEM_HALF: ld_data = {16'b0, addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0]};
         default:  ;
      endcase
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_err_o   = (state_q == RESP) && lat_err;
   assign rsp_rdata_o = (state_q == RESP && !write_q && !lat_err) ? ld_data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with two wait states, one with none, sharing a request bus.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        req_valid, req_write, rsp_ready;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   logic        ready2, valid2, err2, ready0, valid0, err0;
   logic [31:0] rdata2, rdata0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid && !sel), .req_ready_o(ready2),
      .req_write_i(req_write), .req_size_i(req_size),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(valid2), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rdata2), .rsp_err_o(err2)
   );

   mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid && sel), .req_ready_o(ready0),
      .req_write_i(req_write), .req_size_i(req_size),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(valid0), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rdata0), .rsp_err_o(err0)
   );

   assign req_ready = sel ? ready0 : ready2;
   assign rsp_valid = sel ? valid0 : valid2;
   assign rsp_err   = sel ? err0   : err2;
   assign rsp_rdata = sel ? rdata0 : rdata2;

   typedef struct {
      logic        sel;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [0:NV-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_req(input vec_t v, input string tag);
      int cyc;
      int lat;
      sel = v.sel;
      cyc = 0;
      #1;
      while (!req_ready && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
      req_write = v.wr; req_size = v.size; req_addr = v.addr; req_wdata = v.wdata;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, " latency"}, 32'(lat), v.sel ? 32'd1 : 32'd3);
      chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
      chk({tag, " err"}, 32'(rsp_err), 32'(v.exp_err));
      $display("txn %s dut=%0d wr=%0d size=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
               tag, v.sel ? 0 : 2, v.wr, v.size, v.addr, v.wdata, rsp_rdata, rsp_err, lat);
      @(posedge clk); #1;
      chk({tag, " ready_after"}, {30'b0, req_ready, rsp_valid}, 32'b10);
   endtask

   initial begin
      vec_t v;
      vecs[0]  = '{1'b0, 1'b1, 2'b10, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 2'b00, 32'h011, 32'h000000AA, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADAAEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h013, 32'h0,        32'h000000DE, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 2'b01, 32'h012, 32'h0,        32'h0000DEAD, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 2'b01, 32'h011, 32'h0,        32'h0,        1'b1};
      vecs[7]  = '{1'b0, 1'b0, 2'b10, 32'h012, 32'h0,        32'h0,        1'b1};
      vecs[8]  = '{1'b0, 1'b0, 2'b11, 32'h000, 32'h0,        32'h0,        1'b1};
      vecs[9]  = '{1'b0, 1'b1, 2'b10, 32'h000, 32'h11223344, 32'h0,        1'b0};
      vecs[10] = '{1'b0, 1'b1, 2'b10, 32'h400, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[11] = '{1'b0, 1'b1, 2'b01, 32'h011, 32'h00005555, 32'h0,        1'b1};
      vecs[12] = '{1'b0, 1'b0, 2'b10, 32'h000, 32'h0,        32'h11223344, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADAAEF, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 2'b01, 32'h002, 32'h0000BEEF, 32'h0,        1'b0};
      vecs[15] = '{1'b0, 1'b0, 2'b10, 32'h000, 32'h0,        32'hBEEF3344, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 2'b00, 32'h000, 32'h0,        32'h00000044, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 2'b10, 32'h020, 32'h00000000, 32'h0,        1'b0};
      vecs[18] = '{1'b1, 1'b1, 2'b10, 32'h004, 32'hCAFEF00D, 32'h0,        1'b0};
      vecs[19] = '{1'b1, 1'b0, 2'b10, 32'h004, 32'h0,        32'hCAFEF00D, 1'b0};
      vecs[20] = '{1'b1, 1'b0, 2'b01, 32'h006, 32'h0,        32'h0000CAFE, 1'b0};
      vecs[21] = '{1'b1, 1'b0, 2'b00, 32'h005, 32'h0,        32'h000000F0, 1'b0};
      vecs[22] = '{1'b1, 1'b1, 2'b00, 32'h3FF, 32'h0000005A, 32'h0,        1'b0};

      rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_size = 2'b00; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset dut2", {ready2, valid2, err2, 29'b0} | rdata2, {3'b100, 29'b0});
      chk("reset dut0", {ready0, valid0, err0, 29'b0} | rdata0, {3'b100, 29'b0});
      rst_n = 1'b1;
      @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         run_req(vecs[i], $sformatf("vec%0d", i));
      end
      v = '{1'b1, 1'b0, 2'b00, 32'h3FF, 32'h0, 32'h0000005A, 1'b0};
      run_req(v, "top_byte");

      // Back-pressure: response must hold for five cycles with rsp_ready low.
      sel = 1'b0; rsp_ready = 1'b0;
      req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 40 && !rsp_valid; c++) begin
         @(posedge clk); #1;
      end
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp valid c%0d", c), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp rdata c%0d", c), rsp_rdata, 32'hDEADAAEF);
         chk($sformatf("bp ready c%0d", c), 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      $display("txn backpressure rdata=%h valid=%0d", rsp_rdata, rsp_valid);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release", {30'b0, req_ready, rsp_valid}, 32'b10);

      // Reset during WAIT of a store: the store must not land.
      sel = 1'b0;
      req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("wait state entered", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async reset", {ready2, valid2, err2, 29'b0} | rdata2, {3'b100, 29'b0});
      @(posedge clk); #1;
      rst_n = 1'b1;
      $display("txn reset_in_wait ready=%0d valid=%0d", req_ready, rsp_valid);
      @(posedge clk);
      v = '{1'b0, 1'b0, 2'b10, 32'h020, 32'h0, 32'h00000000, 1'b0};
      run_req(v, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
